stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Stopwatch control/count stage fed by the clock divider's 1 Hz output (tick_in).
//  Synchronises and edge-detects tick_in; debounces start/stop, increment and clear keys.
//  Runs an IDLE/RUN/PAUSE state machine and holds MM:SS as 4 BCD digits for the display stage.
//  Single clock domain; tick_in is a level treated as asynchronous.
// PARAMETERS
//  DB_CYCLES  240000  clk cycles a key must be stable to register (20 ms @ 12 MHz); >=2
//  DB_WIDTH   18      debounce counter width; DB_CYCLES < 2**DB_WIDTH
// PORTS
//  clk        in   1  system clock, 12 MHz
//  rst_n      in   1  asynchronous active-low reset
//  tick_in    in   1  divided clock, 1 Hz, 50% duty; rising edge = one second
//  key_ss_n   in   1  start/stop key, raw, active-low
//  key_inc_n  in   1  increment key, raw, active-low
//  key_clr_n  in   1  clear key, raw, active-low
//  sec_bcd    out  8  seconds {tens[7:4] 0-5, ones[3:0] 0-9}
//  min_bcd    out  8  minutes {tens[7:4] 0-5, ones[3:0] 0-9}
//  state      out  2  00 IDLE, 01 RUN, 10 PAUSE (11 unused, decodes to IDLE)
//  running    out  1  1 when state==RUN
//  wrap       out  1  one-cycle pulse when 59:59 advances to 00:00
// BEHAVIOUR
//  Reset: all regs 0; sec_bcd=min_bcd=0, state=IDLE, running=0, wrap=0; sync flops reset to 1 (keys), 0 (tick).
//  tick: 2-flop sync, registered edge detect; rising edge sampled at edge k -> count updates at edge k+2.
//  keys: 2-flop sync, then per-key counter; press = synced low for DB_CYCLES consecutive cycles.
//   Press emits one 1-cycle pulse; re-arm only after key is synced high for DB_CYCLES cycles (no auto-repeat).
//   A glitch shorter than DB_CYCLES resets the counter, producing no pulse.
//  FSM (priority clr > ss > inc > tick, evaluated same cycle):
//   clr pulse : any state -> IDLE, all digits 0; any same-cycle tick/ss/inc is discarded.
//   ss pulse  : IDLE->RUN, RUN->PAUSE, PAUSE->RUN. Count is unchanged on that edge.
//   inc pulse : IDLE or PAUSE: +1 second with carry; state unchanged. Ignored in RUN.
//   inc + ss in the same cycle: ss is applied and inc is dropped.
//   tick pulse: RUN only: +1 second; ignored in IDLE and PAUSE.
//   tick + ss in the same cycle while in RUN: no increment, -> PAUSE.
//  Arithmetic: BCD ripple sec_ones 9->0 carries to sec_tens; 5->0 carries to min_ones, and so on.
//   59:59 +1 -> 00:00 with wrap=1 for one cycle (from inc or tick).
//   State is unchanged on wrap; RUN continues.
//  Outputs are registered; no combinational path from any input to any output.
//  Reset asserted mid-count clears everything immediately; debounce counters restart from 0.
// CONFIGURATION
//  LAP_EN defined:
//   Adds input key_lap_n (1, raw, active-low), debounced identically.
//   Adds output lap_hold (1), which resets to 0.
//   Lap press in RUN toggles lap_hold.
//   While lap_hold=1: sec_bcd/min_bcd freeze at the value present at the press; the internal count keeps running.
//   lap_hold clears (display shows live count next cycle) on: second lap press, clr, ss, or any exit from RUN.
//   Lap press outside RUN is ignored. Priority: clr > ss > lap > inc > tick.
//  LAP_EN undefined: key_lap_n and lap_hold are absent; outputs always show the live count.
// TESTING (DB_CYCLES=4 in sim; tick_in driven as slow square wave)
//  1. Reset, then 3 tick_in rising edges in IDLE -> sec_bcd=00, state=00.
//  2. ss press (low 6 cycles) -> state=01 after debounce+2 cycles; 12 ticks -> sec_bcd=0x12, min_bcd=0x00.
//  3. Two ss presses in succession -> PAUSE then RUN.
//     A tick arriving while in PAUSE leaves the count unchanged.
//     inc pressed in PAUSE from 00:09 -> 0x10 in sec_bcd.
//  4. Preload 59:58 via inc in PAUSE, then RUN with 2 ticks -> 59:59, then 00:00.
//     wrap=1 for exactly 1 cycle; state stays 01.
//  5. Key bounce: key_inc_n low 2 cycles, high 1, low 3 -> no pulse.
//     Then low 6 cycles -> exactly one increment; holding low 50 cycles -> still one.
//  6. clr and ss pulses aligned in the same cycle while in RUN at 00:07 -> state=00, count 00:00.
//     rst_n pulsed low mid-RUN -> all outputs 0 asynchronously.
//  LAP_EN: RUN at 00:03, lap press -> display holds 0x03 while 4 ticks occur.
//   Second lap press -> display 0x07, lap_hold=0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_if
// Desc     : Key/tick inputs and MM:SS display outputs of the stopwatch stage.
//            Lap key and lap_hold exist only when LAP_EN is defined.
// Revision : 1.0
// ============================================================================
interface stopwatch_ctrl_if;
    logic       tick_in;
    logic       key_ss_n;
    logic       key_inc_n;
    logic       key_clr_n;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [1:0] state;
    logic       running;
    logic       wrap;
`ifdef LAP_EN
    logic       key_lap_n;
    logic       lap_hold;

    modport master (
        output tick_in, key_ss_n, key_inc_n, key_clr_n, key_lap_n,
        input  sec_bcd, min_bcd, state, running, wrap, lap_hold
    );
    modport slave (
        input  tick_in, key_ss_n, key_inc_n, key_clr_n, key_lap_n,
        output sec_bcd, min_bcd, state, running, wrap, lap_hold
    );
`else
    modport master (
        output tick_in, key_ss_n, key_inc_n, key_clr_n,
        input  sec_bcd, min_bcd, state, running, wrap
    );
    modport slave (
        input  tick_in, key_ss_n, key_inc_n, key_clr_n,
        output sec_bcd, min_bcd, state, running, wrap
    );
`endif
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Desc     : MM:SS BCD stopwatch: tick sync/edge detect, key debounce and
//            IDLE/RUN/PAUSE control. Optional lap display hold via LAP_EN.
// Revision : 1.0
// ============================================================================
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 240000,
    parameter int DB_WIDTH  = 18
) (
    input wire              clk,
    input wire              rst_n,
    stopwatch_ctrl_if.slave bus
);

    localparam int c_KEY_SS  = 0;
    localparam int c_KEY_INC = 1;
    localparam int c_KEY_CLR = 2;
`ifdef LAP_EN
    localparam int c_KEY_LAP  = 3;
    localparam int c_NUM_KEYS = 4;
`else
    localparam int c_NUM_KEYS = 3;
`endif
    localparam logic [DB_WIDTH-1:0] c_DB_LAST = DB_WIDTH'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    logic [c_NUM_KEYS-1:0] w_key_raw;
    logic [c_NUM_KEYS-1:0] w_press;

`ifdef LAP_EN
    assign w_key_raw = {bus.key_lap_n, bus.key_clr_n, bus.key_inc_n, bus.key_ss_n};
`else
    assign w_key_raw = {bus.key_clr_n, bus.key_inc_n, bus.key_ss_n};
`endif

    // r_armed=1 waits for a stable low (press); r_armed=0 waits for a stable high (re-arm).
    for (genvar gi = 0; gi < c_NUM_KEYS; gi++) begin : g_key
        logic                r_s1;
        logic                r_s2;
        logic                r_armed;
        logic                r_press;
        logic [DB_WIDTH-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1    <= 1'b1;
                r_s2    <= 1'b1;
                r_armed <= 1'b1;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_key_raw[gi];
                r_s2    <= r_s1;
                r_press <= 1'b0;
                if (r_s2 == r_armed) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt   <= '0;
                    r_armed <= ~r_armed;
                    r_press <= r_armed;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    logic   r_tick_s1;
    logic   r_tick_s2;
    logic   r_tick_s3;
    logic   w_tick;
    state_t r_state;
    state_t w_state_nxt;
    logic [7:0] r_sec;
    logic [7:0] r_min;
    logic [7:0] w_sec_nxt;
    logic [7:0] w_min_nxt;
    logic   r_wrap;
    logic   w_wrap_nxt;
    logic   w_step;
`ifdef LAP_EN
    logic       r_hold;
    logic       w_hold_nxt;
    logic       w_capture;
    logic [7:0] r_disp_sec;
    logic [7:0] r_disp_min;
`endif

    assign w_tick = r_tick_s2 & ~r_tick_s3;

    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_wrap_nxt  = 1'b0;
        w_step      = 1'b0;
`ifdef LAP_EN
        w_hold_nxt  = r_hold;
        w_capture   = 1'b0;
`endif
        if (w_press[c_KEY_CLR]) begin
            w_state_nxt = S_IDLE;
            w_sec_nxt   = 8'h00;
            w_min_nxt   = 8'h00;
`ifdef LAP_EN
            w_hold_nxt  = 1'b0;
`endif
        end else if (w_press[c_KEY_SS]) begin
            w_state_nxt = (r_state == S_RUN) ? S_PAUSE : S_RUN;
`ifdef LAP_EN
            w_hold_nxt  = 1'b0;
`endif
        end
`ifdef LAP_EN
        else if (w_press[c_KEY_LAP] && (r_state == S_RUN)) begin
            w_hold_nxt = ~r_hold;
            w_capture  = ~r_hold;
        end
`endif
        else if (w_press[c_KEY_INC] && (r_state != S_RUN)) begin
            w_step = 1'b1;
        end else if (w_tick && (r_state == S_RUN)) begin
            w_step = 1'b1;
        end

        if (w_step) begin
            if (r_sec[3:0] != 4'd9) begin
                w_sec_nxt[3:0] = r_sec[3:0] + 4'd1;
            end else begin
                w_sec_nxt[3:0] = 4'd0;
                if (r_sec[7:4] != 4'd5) begin
                    w_sec_nxt[7:4] = r_sec[7:4] + 4'd1;
                end else begin
                    w_sec_nxt[7:4] = 4'd0;
                    if (r_min[3:0] != 4'd9) begin
                        w_min_nxt[3:0] = r_min[3:0] + 4'd1;
                    end else begin
                        w_min_nxt[3:0] = 4'd0;
                        if (r_min[7:4] != 4'd5) begin
                            w_min_nxt[7:4] = r_min[7:4] + 4'd1;
                        end else begin
                            w_min_nxt[7:4] = 4'd0;
                            w_wrap_nxt     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_s1  <= 1'b0;
            r_tick_s2  <= 1'b0;
            r_tick_s3  <= 1'b0;
            r_state    <= S_IDLE;
            r_sec      <= 8'h00;
            r_min      <= 8'h00;
            r_wrap     <= 1'b0;
`ifdef LAP_EN
            r_hold     <= 1'b0;
            r_disp_sec <= 8'h00;
            r_disp_min <= 8'h00;
`endif
        end else begin
            r_tick_s1  <= bus.tick_in;
            r_tick_s2  <= r_tick_s1;
            r_tick_s3  <= r_tick_s2;
            r_state    <= w_state_nxt;
            r_sec      <= w_sec_nxt;
            r_min      <= w_min_nxt;
            r_wrap     <= w_wrap_nxt;
`ifdef LAP_EN
            r_hold     <= w_hold_nxt;
            // Freeze on the count present at the press; otherwise track the live count.
            if (w_capture) begin
                r_disp_sec <= r_sec;
                r_disp_min <= r_min;
            end else if (!w_hold_nxt) begin
                r_disp_sec <= w_sec_nxt;
                r_disp_min <= w_min_nxt;
            end
`endif
        end
    end

`ifdef LAP_EN
    assign bus.sec_bcd  = r_disp_sec;
    assign bus.min_bcd  = r_disp_min;
    assign bus.lap_hold = r_hold;
`else
    assign bus.sec_bcd  = r_sec;
    assign bus.min_bcd  = r_min;
`endif
    assign bus.state    = r_state;
    assign bus.running  = (r_state == S_RUN);
    assign bus.wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Desc     : Directed self-checking bench for stopwatch_ctrl (DB_CYCLES=4).
//            Lap scenario is compiled in when LAP_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   wrap_cycles;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .DB_CYCLES (4),
        .DB_WIDTH  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (sw_if.wrap === 1'b1) wrap_cycles++;

    // mask bits: {lap, clr, inc, ss}; a set bit drives that key low
    task automatic set_keys(input logic [3:0] mask);
        sw_if.key_ss_n  = ~mask[0];
        sw_if.key_inc_n = ~mask[1];
        sw_if.key_clr_n = ~mask[2];
`ifdef LAP_EN
        sw_if.key_lap_n = ~mask[3];
`endif
    endtask

    task automatic press(input logic [3:0] mask, input int low, input int high);
        set_keys(mask);
        repeat (low) @(negedge clk);
        set_keys(4'h0);
        repeat (high) @(negedge clk);
    endtask

    task automatic tick_pulse();
        sw_if.tick_in = 1'b1;
        repeat (5) @(negedge clk);
        sw_if.tick_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_if.tick_in = 1'b0;
        set_keys(4'h0);
        repeat (3) @(negedge clk);
        checks++; if (sw_if.sec_bcd !== 8'h00) begin errors++; $display("FAIL reset_sec got %h exp 00", sw_if.sec_bcd); end
        checks++; if (sw_if.min_bcd !== 8'h00) begin errors++; $display("FAIL reset_min got %h exp 00", sw_if.min_bcd); end
        checks++; if (sw_if.state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", sw_if.state); end
        checks++; if (sw_if.running !== 1'b0 || sw_if.wrap !== 1'b0) begin errors++; $display("FAIL reset_flags got run=%b wrap=%b exp 0 0", sw_if.running, sw_if.wrap); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        repeat (3) tick_pulse();
        checks++; if (sw_if.sec_bcd !== 8'h00) begin errors++; $display("FAIL idle_tick_sec got %h exp 00", sw_if.sec_bcd); end
        checks++; if (sw_if.state !== 2'b00) begin errors++; $display("FAIL idle_tick_state got %b exp 00", sw_if.state); end
    endtask

    task automatic test_run();
        press(4'b0001, 6, 10);
        checks++; if (sw_if.state !== 2'b01 || sw_if.running !== 1'b1) begin errors++; $display("FAIL run_state got %b/%b exp 01/1", sw_if.state, sw_if.running); end
        repeat (12) tick_pulse();
        checks++; if (sw_if.sec_bcd !== 8'h12) begin errors++; $display("FAIL run_sec got %h exp 12", sw_if.sec_bcd); end
        checks++; if (sw_if.min_bcd !== 8'h00) begin errors++; $display("FAIL run_min got %h exp 00", sw_if.min_bcd); end
    endtask

    task automatic test_pause();
        press(4'b0001, 6, 10);
        checks++; if (sw_if.state !== 2'b10) begin errors++; $display("FAIL pause_state got %b exp 10", sw_if.state); end
        tick_pulse();
        checks++; if (sw_if.sec_bcd !== 8'h12) begin errors++; $display("FAIL pause_tick got %h exp 12", sw_if.sec_bcd); end
        press(4'b0001, 6, 10);
        checks++; if (sw_if.state !== 2'b01) begin errors++; $display("FAIL resume_state got %b exp 01", sw_if.state); end
        press(4'b0100, 6, 10);
        checks++; if (sw_if.state !== 2'b00 || sw_if.sec_bcd !== 8'h00) begin errors++; $display("FAIL clr got state=%b sec=%h exp 00/00", sw_if.state, sw_if.sec_bcd); end
        repeat (9) press(4'b0010, 5, 6);
        checks++; if (sw_if.sec_bcd !== 8'h09) begin errors++; $display("FAIL inc_idle got %h exp 09", sw_if.sec_bcd); end
        press(4'b0001, 6, 10);
        press(4'b0001, 6, 10);
        press(4'b0010, 6, 10);
        checks++; if (sw_if.sec_bcd !== 8'h10 || sw_if.state !== 2'b10) begin errors++; $display("FAIL inc_pause got sec=%h state=%b exp 10/10", sw_if.sec_bcd, sw_if.state); end
    endtask

    task automatic test_wrap();
        int w0;
        press(4'b0100, 6, 10);
        for (int i = 0; i < 3598; i++) begin
            press(4'b0010, 5, 6);
            if (i == 59) begin
                checks++; if (sw_if.min_bcd !== 8'h01 || sw_if.sec_bcd !== 8'h00) begin errors++; $display("FAIL carry_min got %h:%h exp 01:00", sw_if.min_bcd, sw_if.sec_bcd); end
            end
            if (i == 599) begin
                checks++; if (sw_if.min_bcd !== 8'h10 || sw_if.sec_bcd !== 8'h00) begin errors++; $display("FAIL carry_10min got %h:%h exp 10:00", sw_if.min_bcd, sw_if.sec_bcd); end
            end
        end
        checks++; if (sw_if.min_bcd !== 8'h59 || sw_if.sec_bcd !== 8'h58) begin errors++; $display("FAIL preload got %h:%h exp 59:58", sw_if.min_bcd, sw_if.sec_bcd); end
        checks++; if (wrap_cycles !== 0) begin errors++; $display("FAIL early_wrap got %0d exp 0", wrap_cycles); end
        press(4'b0001, 6, 10);
        w0 = wrap_cycles;
        tick_pulse();
        checks++; if (sw_if.min_bcd !== 8'h59 || sw_if.sec_bcd !== 8'h59) begin errors++; $display("FAIL tick_5959 got %h:%h exp 59:59", sw_if.min_bcd, sw_if.sec_bcd); end
        tick_pulse();
        checks++; if (sw_if.min_bcd !== 8'h00 || sw_if.sec_bcd !== 8'h00) begin errors++; $display("FAIL wrap_count got %h:%h exp 00:00", sw_if.min_bcd, sw_if.sec_bcd); end
        checks++; if (wrap_cycles - w0 !== 1) begin errors++; $display("FAIL wrap_pulse got %0d cycles exp 1", wrap_cycles - w0); end
        checks++; if (sw_if.state !== 2'b01) begin errors++; $display("FAIL wrap_state got %b exp 01", sw_if.state); end
    endtask

    task automatic test_bounce();
        press(4'b0001, 6, 10);
        set_keys(4'b0010); repeat (2) @(negedge clk);
        set_keys(4'b0000); repeat (1) @(negedge clk);
        set_keys(4'b0010); repeat (3) @(negedge clk);
        set_keys(4'b0000); repeat (10) @(negedge clk);
        checks++; if (sw_if.sec_bcd !== 8'h00) begin errors++; $display("FAIL bounce got %h exp 00", sw_if.sec_bcd); end
        press(4'b0010, 6, 10);
        checks++; if (sw_if.sec_bcd !== 8'h01) begin errors++; $display("FAIL clean_press got %h exp 01", sw_if.sec_bcd); end
        set_keys(4'b0010);
        repeat (50) @(negedge clk);
        checks++; if (sw_if.sec_bcd !== 8'h02) begin errors++; $display("FAIL held_press got %h exp 02", sw_if.sec_bcd); end
        set_keys(4'b0000);
        repeat (10) @(negedge clk);
        checks++; if (sw_if.sec_bcd !== 8'h02) begin errors++; $display("FAIL held_release got %h exp 02", sw_if.sec_bcd); end
    endtask

    task automatic test_clr_ss();
        press(4'b0001, 6, 10);
        press(4'b0010, 6, 10);
        checks++; if (sw_if.sec_bcd !== 8'h02 || sw_if.state !== 2'b01) begin errors++; $display("FAIL inc_in_run got sec=%h state=%b exp 02/01", sw_if.sec_bcd, sw_if.state); end
        repeat (5) tick_pulse();
        checks++; if (sw_if.sec_bcd !== 8'h07) begin errors++; $display("FAIL run_07 got %h exp 07", sw_if.sec_bcd); end
        press(4'b0101, 6, 10);
        checks++; if (sw_if.state !== 2'b00 || sw_if.sec_bcd !== 8'h00 || sw_if.min_bcd !== 8'h00) begin errors++; $display("FAIL clr_ss got state=%b %h:%h exp 00 00:00", sw_if.state, sw_if.min_bcd, sw_if.sec_bcd); end
        press(4'b0011, 6, 10);
        checks++; if (sw_if.state !== 2'b01 || sw_if.sec_bcd !== 8'h00) begin errors++; $display("FAIL ss_inc got state=%b sec=%h exp 01/00", sw_if.state, sw_if.sec_bcd); end
        repeat (2) tick_pulse();
        checks++; if (sw_if.sec_bcd !== 8'h02) begin errors++; $display("FAIL pre_reset got %h exp 02", sw_if.sec_bcd); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sw_if.sec_bcd !== 8'h00 || sw_if.state !== 2'b00 || sw_if.running !== 1'b0) begin errors++; $display("FAIL async_reset got sec=%h state=%b run=%b exp 00/00/0", sw_if.sec_bcd, sw_if.state, sw_if.running); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

`ifdef LAP_EN
    task automatic test_lap();
        press(4'b0001, 6, 10);
        repeat (3) tick_pulse();
        press(4'b1000, 6, 10);
        checks++; if (sw_if.lap_hold !== 1'b1 || sw_if.sec_bcd !== 8'h03) begin errors++; $display("FAIL lap_on got hold=%b sec=%h exp 1/03", sw_if.lap_hold, sw_if.sec_bcd); end
        repeat (4) tick_pulse();
        checks++; if (sw_if.sec_bcd !== 8'h03) begin errors++; $display("FAIL lap_freeze got %h exp 03", sw_if.sec_bcd); end
        press(4'b1000, 6, 10);
        checks++; if (sw_if.lap_hold !== 1'b0 || sw_if.sec_bcd !== 8'h07) begin errors++; $display("FAIL lap_off got hold=%b sec=%h exp 0/07", sw_if.lap_hold, sw_if.sec_bcd); end
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        wrap_cycles = 0;
        test_reset();
        test_run();
        test_pause();
        test_wrap();
        test_bounce();
        test_clr_ss();
`ifdef LAP_EN
        test_lap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
